keypad_scan_ctrl: RTL
=====================

// Module: keypad_scan_ctrl
// PURPOSE
//  Scan controller for the 4x4 matrix keypad on the mcu_io side of the system.
//  Walks an active-low strobe across Keypad_cols, samples Keypad_rows and debounces one key.
//  Encodes the key to an 8-bit code and hands it to the MCU keyboard input (KB) over valid/ready.
//  Single clock domain (clk); rst is synchronous and active-high.
// PARAMETERS
//  SCAN_DIV        50000  clk cycles per column dwell; one "tick" ends each dwell (>=2)
//  DEBOUNCE_SCANS  4      consecutive matching ticks needed to accept a press or a release (>=1)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous reset, active-high
//  Keypad_rows  in   4  row sense, active-low, externally pulled up; asynchronous to clk
//  Keypad_cols  out  4  column strobe, active-low one-hot (exactly one bit 0 at all times)
//  key_code     out  8  {4'h0, code}: digits 0-9 -> 0x00-0x09, A-D -> 0x0A-0x0D, * -> 0x0E, # -> 0x0F
//  key_valid    out  1  key_code holds an unconsumed key
//  key_ready    in   1  consumer accepts key_code when key_valid && key_ready
//  key_held     out  1  debounced key currently down (HOLD or RELEASE state)
// BEHAVIOUR
//  Reset values (next edge after rst=1, regardless of state):
//   Keypad_cols=4'b1110, col=0, key_code=8'h00, key_valid=0, key_held=0, state=SCAN,
//   divider=0, debounce count=0, synchronizer flops=4'hF.
//  Rows pass through a 2-flop synchronizer (rows_s); all decisions use rows_s.
//  tick = 1 for one cycle when the divider reaches SCAN_DIV-1; the divider then wraps to 0.
//  Keypad_cols = ~(4'b0001 << col); col advances only on a tick in SCAN, 3 wraps to 0.
//  States:
//   SCAN:
//    - On a tick with key_valid=0 and rows_s having exactly one bit low:
//      latch col/row into cand, freeze col, count=1, go to DEBOUNCE.
//    - On a tick with all rows high, multiple rows low, or key_valid=1: advance col, stay.
//   DEBOUNCE (col frozen):
//    - On each tick: if rows_s equals the latched pattern, count++.
//      At count==DEBOUNCE_SCANS go to HOLD; that same cycle load key_code=KEYMAP[row][col],
//      set key_valid=1, set key_held=1.
//    - On a tick with a mismatch: go to SCAN and advance col. No code is issued.
//   HOLD (col frozen):
//    - On a tick with rows_s==4'hF: count=1, go to RELEASE.
//    - Any other pattern keeps HOLD; no roll-over, no auto-repeat.
//   RELEASE (col frozen):
//    - On a tick with rows_s==4'hF: count++. At count==DEBOUNCE_SCANS: key_held=0,
//      go to SCAN and advance col.
//    - On a tick with any row low: return to HOLD (bounce on release).
//  Handshake (independent of FSM state):
//   - key_valid && key_ready at an edge clears key_valid at that edge.
//   - key_code holds its value until the next accepted press; it is not cleared on accept.
//   - key_valid never drops without key_ready. No new press is latched while key_valid=1,
//     so an unconsumed code is never overwritten.
//   - ready asserted in the same cycle valid rises: the key is consumed at the next edge (1-cycle pulse).
//  Latency: a press stable before a tick produces key_valid 1 clk after the
//   DEBOUNCE_SCANS-th matching tick, plus 2 clk of synchronizer delay on the row edge.
//  Widths: divider $clog2(SCAN_DIV) bits; count $clog2(DEBOUNCE_SCANS+1) bits, saturating.
// STRUCTURE
//  Package keypad_pkg:
//   - state encoding localparams (SCAN/DEBOUNCE/HOLD/RELEASE);
//   - KEYMAP[row][col], 4x4 of 4-bit codes:
//       row0: 1 2 3 A
//       row1: 4 5 6 B
//       row2: 7 8 9 C
//       row3: E(*) 0 F(#) D
//   - KEY_NONE=8'h00.
//  Sub-module kp_tick_div (parameter SCAN_DIV): free-running divider with sync reset, emits tick.
//  Top level holds the synchronizer, FSM, column register, count and handshake register.
// TESTING (bench uses SCAN_DIV=4, DEBOUNCE_SCANS=3; keypad model shorts row to the driven col)
//  1. rst=1 for 2 clk, rows=4'hF
//     -> Keypad_cols=4'b1110, key_valid=0, key_held=0, key_code=8'h00;
//        after release, cols step 1110->1101->1011->0111->1110, one step every 4 clk.
//  2. Hold key '6' (row1,col2) stable, key_ready=0
//     -> key_code=8'h06, key_valid=1, key_held=1 after 3 matching ticks;
//        valid stays 1 until ready=1 for 1 clk, then 0 on the next edge.
//  3. Bounce: row0 low for 1 tick on col0, then high
//     -> no key_valid; FSM returns to SCAN and Keypad_cols advances to 4'b1101.
//  4. Row0 and row3 low together on col1
//     -> no DEBOUNCE entry, no key issued; scan continues.
//  5. Press '#' with key_ready=0 and pending code 0x06
//     -> key_code stays 8'h06; after accept, '#' is latched on a later scan -> key_code=8'h0F.
//  6. rst=1 mid-DEBOUNCE and mid-HOLD with valid=1
//     -> all outputs return to reset values at the next edge; no stale key after rst falls.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller:
// FSM state encoding, key code map and row-pattern helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    localparam logic [7:0] KEY_NONE = 8'h00;

    // KEYMAP[row][col]; '*' encodes as 0xE and '#' as 0xF
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // True when exactly one active-low row is asserted
    function automatic logic one_low(input logic [3:0] rows);
        return ($countones(~rows) == 1);
    endfunction

    function automatic logic [1:0] low_idx(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        case (rows)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/kp_tick_div.sv
// Free-running column dwell divider; tick is high for the last cycle of each dwell.
module kp_tick_div #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0] div;

    assign tick = (div == DW'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)       div <= '0;
        else if (tick) div <= '0;
        else           div <= div + DW'(1);
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column strobe, row synchronizer, single-key debounce FSM
// and a valid/ready output register holding the encoded key.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Keypad_rows,
    output logic [3:0] Keypad_cols,
    output logic [7:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held
);

    localparam int CW = (DEBOUNCE_SCANS > 0) ? $clog2(DEBOUNCE_SCANS + 1) : 1;

    logic          tick;
    logic [3:0]    rows_m, rows_s;
    kp_state_t     state, state_next;
    logic [1:0]    col, col_next;
    logic [CW-1:0] cnt, cnt_next, cnt_inc;
    logic [3:0]    cand_pat;
    logic [1:0]    cand_row;
    logic          latch, load, clr_held;

    kp_tick_div #(.SCAN_DIV(SCAN_DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign Keypad_cols = ~(4'b0001 << col);
    assign cnt_inc     = (cnt == '1) ? cnt : cnt + CW'(1);

    // Rows are asynchronous to clk; only rows_s feeds decisions
    always_ff @(posedge clk) begin
        if (rst) begin
            rows_m <= 4'hF;
            rows_s <= 4'hF;
        end else begin
            rows_m <= Keypad_rows;
            rows_s <= rows_m;
        end
    end

    always_comb begin
        state_next = state;
        col_next   = col;
        cnt_next   = cnt;
        latch      = 1'b0;
        load       = 1'b0;
        clr_held   = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    // A pending code blocks new presses so it is never overwritten
                    if (!key_valid && one_low(rows_s)) begin
                        latch      = 1'b1;
                        cnt_next   = CW'(1);
                        state_next = DEBOUNCE;
                    end else begin
                        col_next = col + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (rows_s == cand_pat) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc >= CW'(DEBOUNCE_SCANS)) begin
                            load       = 1'b1;
                            state_next = HOLD;
                        end
                    end else begin
                        state_next = SCAN;
                        col_next   = col + 2'd1;
                    end
                end
                HOLD: begin
                    if (rows_s == 4'hF) begin
                        cnt_next   = CW'(1);
                        state_next = RELEASE;
                    end
                end
                RELEASE: begin
                    if (rows_s == 4'hF) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc >= CW'(DEBOUNCE_SCANS)) begin
                            clr_held   = 1'b1;
                            state_next = SCAN;
                            col_next   = col + 2'd1;
                        end
                    end else begin
                        state_next = HOLD;
                    end
                end
                default: state_next = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SCAN;
            col      <= 2'd0;
            cnt      <= '0;
            cand_pat <= 4'hF;
            cand_row <= 2'd0;
        end else begin
            state <= state_next;
            col   <= col_next;
            cnt   <= cnt_next;
            if (latch) begin
                cand_pat <= rows_s;
                cand_row <= low_idx(rows_s);
            end
        end
    end

    // key_code persists after accept; only a new debounced press replaces it
    always_ff @(posedge clk) begin
        if (rst) begin
            key_code  <= KEY_NONE;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            if (load) begin
                key_code  <= {4'h0, KEYMAP[cand_row][col]};
                key_valid <= 1'b1;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
            if (load)          key_held <= 1'b1;
            else if (clr_held) key_held <= 1'b0;
        end
    end

endmodule
